// File: rtl/key_row_scanner_pkg.sv
// ---------------------------------------------------------------------------
// key_scan_pkg
//   Shared widths, the scanner state encoding, and the small column-decode
//   helpers used by the keypad row scanner and its handshake interface.
//
//   ROW_W       width of the row address (8 rows)
//   COL_W       width of the column index (4 columns)
//   KEY_W       width of a key code {row, col_idx}
//   NCOL        number of column return lines
//   state_t     scanner FSM states
//   lowest_set  index of the lowest set bit of a column vector (0 if none)
//   multi_hot   1 when more than one column bit is set
// ---------------------------------------------------------------------------
package key_scan_pkg;

  localparam int ROW_W = 3;
  localparam int COL_W = 2;
  localparam int KEY_W = ROW_W + COL_W;
  localparam int NCOL  = 4;

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_REPORT  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Walk from the top bit down so the last hit is the lowest set index.
  function automatic logic [COL_W-1:0] lowest_set(input logic [NCOL-1:0] col);
    logic [COL_W-1:0] idx;
    idx = '0;
    for (int i = NCOL - 1; i >= 0; i--) begin
      if (col[i]) begin
        idx = COL_W'(i);
      end
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic multi_hot(input logic [NCOL-1:0] col);
    return |(col & (col - NCOL'(1)));
  endfunction

endpackage

// File: rtl/key_row_scanner_if.sv
// ---------------------------------------------------------------------------
// key_row_scanner_if
//   Valid/ready handshake that carries one key code per press from the row
//   scanner to its downstream consumer.
//
//   key_valid  scanner -> consumer  key_code/key_multi are valid
//   key_ready  consumer -> scanner  consumer accepts on key_valid & key_ready
//   key_code   scanner -> consumer  {row[2:0], col_idx[1:0]}
//   key_multi  scanner -> consumer  several columns were set at latch time
//
//   master: the scanner side; slave: the consumer side.
// ---------------------------------------------------------------------------
interface key_row_scanner_if;
  import key_scan_pkg::*;

  logic             key_valid;
  logic             key_ready;
  logic [KEY_W-1:0] key_code;
  logic             key_multi;

  modport master (
    output key_valid,
    output key_code,
    output key_multi,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  key_multi,
    output key_ready
  );

endinterface

// File: rtl/key_row_scanner_sync2.sv
// ---------------------------------------------------------------------------
// sync2
//   Two-flop synchroniser for a bus of independent asynchronous bits. Each
//   bit is synchronised on its own; no coherency across bits is implied.
//
//   clk  in      destination clock
//   rst  in      asynchronous active-high clear
//   d    in  W   asynchronous input
//   q    out W   synchronised output (two clk edges of latency)
// ---------------------------------------------------------------------------
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_row_scanner.sv
// ---------------------------------------------------------------------------
// key_row_scanner
//   Drives the address of the 3-to-8 keypad row decoder, samples the column
//   return lines once per row dwell, debounces a press, hands one key code
//   per press to the consumer over a valid/ready handshake, then debounces
//   the release before scanning resumes on the following row.
//
//   Parameters
//     DWELL     cycles each row is held; >= 3 so the synchronised columns
//               have settled before the sample edge
//     DEBOUNCE  consecutive matching samples to accept a press or release
//
//   Ports
//     clk       in      single clock, rising edge
//     rst       in      asynchronous active-high reset
//     scan_en   in      scanning allowed (only looked at while scanning)
//     col_in    in  4   column return lines, active-high, asynchronous
//     row_sel   out 3   row address to the decoder
//     row_en    out     decoder enable
//     key_if    master  key_valid/key_ready/key_code/key_multi handshake
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   SCAN     | step rows, sample each row once per dwell, look for a column
//   CONFIRM  | row held, count samples that still show the latched column
//   REPORT   | key_valid high, code frozen until the consumer accepts
//   RELEASE  | row held, count samples with the latched column clear
// ---------------------------------------------------------------------------
module key_row_scanner
  import key_scan_pkg::*;
#(
  parameter int DWELL    = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_en,
  input  logic [NCOL-1:0]  col_in,
  output logic [ROW_W-1:0] row_sel,
  output logic             row_en,
  key_row_scanner_if.master key_if
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int DB_W = $clog2(DEBOUNCE + 1);

  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE - 1);

  state_t           state;
  state_t           state_nxt;

  logic [NCOL-1:0]  col_s;
  logic [DW_W-1:0]  dwell_cnt;
  logic [DB_W-1:0]  match_cnt;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_idx;
  logic             multi_q;

  logic             dwell_run;
  logic             sample;
  logic             col_any;
  logic             col_hit;
  logic             accept;

  sync2 #(
    .WIDTH (NCOL)
  ) u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (col_in),
    .q   (col_s)
  );

  // The dwell counter only stalls while scanning is disabled in SCAN; once a
  // key is being tracked, the row is held and the counter keeps sampling.
  assign dwell_run = (state != ST_SCAN) || scan_en;
  assign sample    = dwell_run && (dwell_cnt == DWELL_LAST);
  assign col_any   = |col_s;
  assign col_hit   = col_s[col_idx];
  assign accept    = key_if.key_valid && key_if.key_ready;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_SCAN;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_SCAN: begin
        if (sample && col_any) begin
          state_nxt = ST_CONFIRM;
        end
      end
      ST_CONFIRM: begin
        if (sample) begin
          if (!col_hit) begin
            state_nxt = ST_SCAN;
          end else if (match_cnt == DB_LAST) begin
            state_nxt = ST_REPORT;
          end
        end
      end
      ST_REPORT: begin
        if (accept) begin
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (sample && !col_hit && (match_cnt == DB_LAST)) begin
          state_nxt = ST_SCAN;
        end
      end
      default: state_nxt = ST_SCAN;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // The code latches only change on a SCAN detection, so they are already
  // stable for the whole REPORT window and need no extra gating.
  always_comb begin
    key_if.key_valid = (state == ST_REPORT);
    key_if.key_code  = {row_q, col_idx};
    key_if.key_multi = multi_q;
  end

  // -------------------------------------------------------------------------
  // Dwell counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_cnt <= '0;
    end else if (dwell_run) begin
      if (dwell_cnt == DWELL_LAST) begin
        dwell_cnt <= '0;
      end else begin
        dwell_cnt <= dwell_cnt + DW_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Row address, decoder enable, debounce counter and key latches
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_sel   <= '0;
      row_en    <= 1'b0;
      match_cnt <= '0;
      row_q     <= '0;
      col_idx   <= '0;
      multi_q   <= 1'b0;
    end else begin
      case (state)
        ST_SCAN: begin
          row_en <= scan_en;
          if (sample) begin
            if (col_any) begin
              row_q     <= row_sel;
              col_idx   <= lowest_set(col_s);
              multi_q   <= multi_hot(col_s);
              match_cnt <= '0;
            end else begin
              row_sel <= row_sel + ROW_W'(1);
            end
          end
        end
        ST_CONFIRM: begin
          row_en <= 1'b1;
          if (sample) begin
            if (col_hit) begin
              match_cnt <= match_cnt + DB_W'(1);
            end else begin
              // A bounce: skip past this row so a flaky key cannot pin the scan.
              row_sel <= row_q + ROW_W'(1);
            end
          end
        end
        ST_REPORT: begin
          row_en <= 1'b1;
          if (accept) begin
            match_cnt <= '0;
          end
        end
        ST_RELEASE: begin
          row_en <= 1'b1;
          if (sample) begin
            if (col_hit) begin
              match_cnt <= '0;
            end else if (match_cnt == DB_LAST) begin
              match_cnt <= '0;
              row_sel   <= row_q + ROW_W'(1);
            end else begin
              match_cnt <= match_cnt + DB_W'(1);
            end
          end
        end
        default: begin
          row_en <= scan_en;
        end
      endcase
    end
  end

endmodule
